// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a 4-entry input FIFO.
// Frames are 8N1 by default. Defining UART_TX_PARITY_EN inserts an even
// parity bit after data bit 7, giving 8E1 frames.
// Every serial bit lasts clk_freq / baud_rate clock cycles.
// Frames are sent back-to-back, with no idle cycle between them, while the FIFO holds data.
module uart_tx #(
  parameter int clk_freq  = 50000000,
  parameter int baud_rate = 19200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic [2:0] fifo_count
);

  localparam int          CLOCK_DIVIDE = clk_freq / baud_rate;
  localparam logic [11:0] DIV_LAST     = 12'(CLOCK_DIVIDE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        rdy_q, rdy_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [4];
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic       push;
  logic       pop;
  logic       bit_end;
  logic [7:0] head;

  // rdy_q already tracks count_q < 4, so a full FIFO never accepts a push
  assign push    = tx_valid & rdy_q;
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (cnt_q == DIV_LAST);

  // Frame sequencer. tx_d is computed from the state being entered, so the
  // line reflects a new state on the same edge that enters it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 12'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (count_q != 3'd0) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (count_q != 3'd0) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping; a push and a pop on the same edge cancel in the count
  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
    rdy_d    = (count_d < 3'd4);
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Datapath registers; reset pointers make any stale contents unreachable
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    par_q   <= par_d;
`endif
    if (push) mem_q[wr_ptr_q] <= tx_data_in;
  end

  assign tx         = tx_q;
  assign tx_ready   = rdy_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random stimulus for uart_tx. A queue-based model
// of the FIFO and of the expected line waveform supplies the expected values.
module tb_uart_tx;

  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] tx_data_in;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_tx #(.clk_freq(CLK_FREQ), .baud_rate(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data_in (tx_data_in),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: bytes waiting, and the remaining line levels of the
  // frame in flight (head = level currently on the line).
  logic [7:0] mq[$];
  logic       line_q[$];
  logic       m_ready = 1'b0;

  logic txlog[$];
  int   busy_cycles;
  int   busy_falls;
  logic prev_busy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic build_frame(input logic [7:0] b);
    for (int k = 0; k < DIV; k++) line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < DIV; k++) line_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k < DIV; k++) line_q.push_back(^b);
`endif
    for (int k = 0; k < DIV; k++) line_q.push_back(1'b1);
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [7:0] d);
    logic acc;
    if (!r) begin
      mq.delete();
      line_q.delete();
      m_ready = 1'b0;
    end else begin
      acc = v && m_ready;
      if (line_q.size() > 0) void'(line_q.pop_front());
      if (line_q.size() == 0 && mq.size() > 0) build_frame(mq.pop_front());
      if (acc) mq.push_back(d);
      m_ready = (mq.size() < 4);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [7:0] d);
    logic exp_tx;
    rst        = r;
    tx_valid   = v;
    tx_data_in = d;
    @(posedge clk);
    model_edge(r, v, d);
    #1;
    exp_tx = (line_q.size() > 0) ? line_q[0] : 1'b1;
    check_eq("tx", 32'(tx), 32'(exp_tx));
    check_eq("tx_busy", 32'(tx_busy), 32'(line_q.size() > 0));
    check_eq("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check_eq("tx_ready", 32'(tx_ready), 32'(m_ready));
    txlog.push_back(tx);
    if (tx_busy) busy_cycles++;
    if (prev_busy && !tx_busy) busy_falls++;
    prev_busy = tx_busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 8'h00);
  endtask

  logic [10:0] pat55;
  logic [7:0]  rd;

  initial begin
    rst = 1'b0; tx_valid = 1'b0; tx_data_in = 8'h00;
`ifdef UART_TX_PARITY_EN
    pat55 = 11'b100_1010_1010;
`else
    pat55 = 11'b010_1010_1010;
`endif

    // reset state
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00);
    check_eq("rst_ready", 32'(tx_ready), 32'd0);
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(tx_busy), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    idle(1);
    check_eq("ready_after_rst", 32'(tx_ready), 32'd1);

    // single 0x55 frame: latency, bit pattern, duration
    cycle(1'b1, 1'b1, 8'h55);
    check_eq("accept_edge_tx", 32'(tx), 32'd1);
    txlog.delete(); busy_cycles = 0;
    idle(130);
    check_eq("start_latency", 32'(txlog[0]), 32'd0);
    for (int k = 0; k < FRAME_BITS; k++)
      check_eq("bit55", 32'(txlog[k*DIV + DIV/2]), 32'(pat55[k]));
    check_eq("busy55", 32'(busy_cycles), 32'(DIV * FRAME_BITS));

    // 0x07 frame: bit 9 is parity (1) or stop (1); d7 is 0
    cycle(1'b1, 1'b1, 8'h07);
    txlog.delete(); busy_cycles = 0;
    idle(130);
    check_eq("d7_07", 32'(txlog[8*DIV + DIV/2]), 32'd0);
    check_eq("bit9_07", 32'(txlog[9*DIV + DIV/2]), 32'd1);
    check_eq("busy07", 32'(busy_cycles), 32'(DIV * FRAME_BITS));

    // five back-to-back pushes fill the FIFO; a sixth is dropped
    busy_cycles = 0; busy_falls = 0;
    cycle(1'b1, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hA5);
    cycle(1'b1, 1'b1, 8'h3C);
    cycle(1'b1, 1'b1, 8'h81);
    check_eq("full_count", 32'(fifo_count), 32'd4);
    check_eq("full_ready", 32'(tx_ready), 32'd0);
    cycle(1'b1, 1'b1, 8'h12);
    check_eq("reject_count", 32'(fifo_count), 32'd4);
    idle(600);
    check_eq("burst_busy", 32'(busy_cycles), 32'(5 * DIV * FRAME_BITS));
    check_eq("burst_gapless", 32'(busy_falls), 32'd1);

    // push on the same edge the head is popped
    cycle(1'b1, 1'b1, 8'h3A);
    check_eq("one_queued", 32'(fifo_count), 32'd1);
    cycle(1'b1, 1'b1, 8'hC4);
    check_eq("push_pop_count", 32'(fifo_count), 32'd1);
    idle(260);

    // reset at cycle 35 of a 0x81 frame with two bytes queued
    cycle(1'b1, 1'b1, 8'h81);
    cycle(1'b1, 1'b1, 8'h11);
    cycle(1'b1, 1'b1, 8'h22);
    idle(33);
    check_eq("pre_abort_count", 32'(fifo_count), 32'd2);
    cycle(1'b0, 1'b0, 8'h00);
    check_eq("abort_tx", 32'(tx), 32'd1);
    check_eq("abort_count", 32'(fifo_count), 32'd0);
    check_eq("abort_busy", 32'(tx_busy), 32'd0);
    busy_cycles = 0;
    idle(200);
    check_eq("no_resume", 32'(busy_cycles), 32'd0);

    // random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      rd = 8'($urandom);
      cycle(($urandom_range(0, 599) != 0), ($urandom_range(0, 99) < 30), rd);
    end
    idle(600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
